// File: rtl/com_read_multi.sv
// ---------------------------------------------------------------------------
// com_read_multi
// Command-field reader for the collect-side command path. On a start request
// from the Ethernet receive side it reads a header byte plus NF command fields
// from the receive RAM (read latency LAT cycles), validates the header, hands
// the assembled field vector to the command consumer and acknowledges the
// Ethernet side. A consumer timeout or a bad header raises read_err.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   fs_eth_read  start request from the Ethernet side (level-held)
//   fd_eth_read  done/ack to the Ethernet side
//   fs_read      command valid to the consumer
//   fd_read      consumer has taken the command
//   read_btype   block type, field 0 bits [3:0]
//   com_field    field k at bits [k*DW +: DW]
//   read_err     header mismatch or consumer timeout
//   ram_rxa      registered RAM read address
//   ram_rxd      RAM read data
// ---------------------------------------------------------------------------
module com_read_multi #(
   parameter int              DW         = 8,
   parameter int              AW         = 8,
   parameter int              NF         = 4,
   parameter int              LAT        = 2,
   parameter logic [AW-1:0]   HEAD_ADDR  = 8'h80,
   parameter logic [DW-1:0]   HEAD_VAL   = 8'h55,
   parameter logic [AW-1:0]   ADDR_FIRST = 8'h85,
   parameter logic [AW-1:0]   ADDR_STEP  = 8'h02,
   parameter logic [AW-1:0]   ADDR_IDLE  = 8'h80,
   parameter logic [15:0]     TMO        = 16'd1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fs_eth_read,
   output logic               fd_eth_read,
   output logic               fs_read,
   input  logic               fd_read,
   output logic [3:0]         read_btype,
   output logic [NF*DW-1:0]   com_field,
   output logic               read_err,
   output logic [AW-1:0]      ram_rxa,
   input  logic [DW-1:0]      ram_rxd
);

   // num must reach NF+LAT and take one more increment on the CHECK transition
   localparam int NW = $clog2(NF + LAT + 2);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_READ, S_CHECK, S_TAKE, S_WORK, S_DONE, S_FAIL
   } state_t;

   state_t              state_q, state_d;
   logic [NW-1:0]       num_q, num_d;
   logic [15:0]         tmo_cnt_q, tmo_cnt_d;
   logic [AW-1:0]       ram_rxa_q, ram_rxa_d;
   logic [NF*DW-1:0]    com_field_q, com_field_d;
   logic [3:0]          read_btype_q, read_btype_d;
   // slot 0 = header, slots 1..NF = fields 0..NF-1
   logic [DW-1:0]       slot_q [0:NF];
   logic [DW-1:0]       slot_d [0:NF];
   logic [31:0]         fld_addr;
   logic                abort;

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d      = state_q;
      num_d        = num_q;
      tmo_cnt_d    = tmo_cnt_q;
      ram_rxa_d    = ADDR_IDLE;
      com_field_d  = com_field_q;
      read_btype_d = read_btype_q;
      slot_d       = slot_q;

      // field address for num = k is ADDR_FIRST + (k-1)*ADDR_STEP, wrapping in AW bits
      fld_addr = 32'(ADDR_FIRST) + (32'(num_q) - 32'd1) * 32'(ADDR_STEP);

      abort = !fs_eth_read &&
              (state_q == S_READ || state_q == S_CHECK ||
               state_q == S_TAKE || state_q == S_WORK);

      case (state_q)
         S_IDLE: begin
            com_field_d  = '0;
            read_btype_d = '0;
            num_d        = '0;
            tmo_cnt_d    = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (fs_eth_read) state_d = S_READ;
         end
         S_READ: begin
            num_d = num_q + NW'(1);
            if (num_q == '0)
               ram_rxa_d = HEAD_ADDR;
            else if (num_q <= NW'(NF))
               ram_rxa_d = fld_addr[AW-1:0];
            // data for the address issued at num = j arrives LAT cycles later
            for (int j = 0; j <= NF; j++) begin
               if (num_q == NW'(j + LAT)) slot_d[j] = ram_rxd;
            end
            if (num_q == NW'(NF + LAT)) state_d = S_CHECK;
         end
         S_CHECK: begin
            state_d = (slot_q[0] != HEAD_VAL) ? S_FAIL : S_TAKE;
         end
         S_TAKE: begin
            for (int k = 0; k < NF; k++) com_field_d[k*DW +: DW] = slot_q[k+1];
            read_btype_d = slot_q[1][3:0];
            state_d      = S_WORK;
         end
         S_WORK: begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
            // a take on the terminal-count cycle still counts as success
            if (fd_read)
               state_d = S_DONE;
            else if (tmo_cnt_q == TMO - 16'd1)
               state_d = S_FAIL;
         end
         S_DONE, S_FAIL: begin
            if (!fs_eth_read) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) begin
         state_q      <= S_IDLE;
         num_q        <= '0;
         tmo_cnt_q    <= '0;
         ram_rxa_q    <= ADDR_IDLE;
         com_field_q  <= '0;
         read_btype_q <= '0;
      end else begin
         state_q      <= state_d;
         num_q        <= num_d;
         tmo_cnt_q    <= tmo_cnt_d;
         ram_rxa_q    <= ram_rxa_d;
         com_field_q  <= com_field_d;
         read_btype_q <= read_btype_d;
      end
   end

   // NOTE: the capture slots are not reset; every slot is rewritten in READ before CHECK/TAKE read it.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   assign fs_read     = (state_q == S_WORK);
   assign fd_eth_read = (state_q == S_DONE) || (state_q == S_FAIL);
   assign read_err    = (state_q == S_FAIL);
   assign read_btype  = read_btype_q;
   assign com_field   = com_field_q;
   assign ram_rxa     = ram_rxa_q;

endmodule

// File: tb/tb_com_read_multi.sv
// ---------------------------------------------------------------------------
// tb_com_read_multi
// Directed bench for com_read_multi. Four instances share one RAM image:
//   g=0 : NF=4, LAT=2, ADDR_STEP=2, TMO=16
//   g=1..3 : NF=8, ADDR_STEP=1, LAT=1/3/4
// Expected field vectors are pushed to a scoreboard queue when a request is
// launched and popped when the instance raises fs_read.
// ---------------------------------------------------------------------------
module tb_com_read_multi;

   typedef struct packed {
      logic [63:0] field;
      logic [3:0]  btype;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [7:0]  mem [256];

   logic        fs_eth_read_v [4];
   logic        fd_read_v     [4];
   logic        fd_eth_read_w [4];
   logic        fs_read_w     [4];
   logic        read_err_w    [4];
   logic [3:0]  btype_w       [4];
   logic [63:0] com_field_w   [4];
   logic [7:0]  rxa_w         [4];
   logic [7:0]  rxd_w         [4];

   exp_t        sb_q [$];
   int          n_assert = 0;
   int          n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int          G_NF   = (g == 0) ? 4 : 8;
      localparam int          G_LAT  = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
      localparam logic [7:0]  G_STEP = (g == 0) ? 8'h02 : 8'h01;
      localparam logic [15:0] G_TMO  = (g == 0) ? 16'd16 : 16'd1000;

      logic [G_NF*8-1:0] cf;
      logic [7:0]        dly [0:3];

      com_read_multi #(
         .NF(G_NF), .LAT(G_LAT), .ADDR_STEP(G_STEP), .TMO(G_TMO)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .fs_eth_read(fs_eth_read_v[g]),
         .fd_eth_read(fd_eth_read_w[g]),
         .fs_read(fs_read_w[g]),
         .fd_read(fd_read_v[g]),
         .read_btype(btype_w[g]),
         .com_field(cf),
         .read_err(read_err_w[g]),
         .ram_rxa(rxa_w[g]),
         .ram_rxd(rxd_w[g])
      );

      assign com_field_w[g] = 64'(cf);

      // RAM model: address delayed by LAT-1 registered stages, then looked up
      always @(posedge clk) begin
         dly[0] <= rxa_w[g];
         dly[1] <= dly[0];
         dly[2] <= dly[1];
         dly[3] <= dly[2];
      end
      if (G_LAT == 1) begin : g_comb
         assign rxd_w[g] = mem[rxa_w[g]];
      end else begin : g_reg
         assign rxd_w[g] = mem[dly[G_LAT-2]];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // cycles from the WAIT cycle that saw the request to fs_read; -1 if it never came
   task automatic wait_fs(input int g, output int lat);
      int n = 0;
      while (fs_read_w[g] !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      lat = (fs_read_w[g] === 1'b1) ? n : -1;
   endtask

   task automatic sb_compare(input int g, input string tag);
      exp_t e;
      check({tag, "_sb_pending"}, 64'(sb_q.size()), 64'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_com_field"}, com_field_w[g], e.field);
         check({tag, "_btype"}, 64'(btype_w[g]), 64'(e.btype));
      end
   endtask

   task automatic load_nominal();
      mem[8'h80] = 8'h55;
      mem[8'h85] = 8'hA4;
      mem[8'h87] = 8'h12;
      mem[8'h89] = 8'h34;
      mem[8'h8B] = 8'h56;
   endtask

   initial begin
      int   lat;
      int   cnt;
      int   seen_fs;
      int   seen_ack;
      int   lat_tab [4];
      exp_t e;

      lat_tab = '{2, 1, 3, 4};
      for (int a = 0; a < 256; a++) mem[a] = 8'(a ^ 8'h3C);
      for (int g = 0; g < 4; g++) begin
         fs_eth_read_v[g] = 1'b0;
         fd_read_v[g]     = 1'b0;
      end

      // ---- reset values ----
      rst = 1'b0;
      #22;
      check("rst_fd_eth_read", 64'(fd_eth_read_w[0]), 64'd0);
      check("rst_fs_read",     64'(fs_read_w[0]),     64'd0);
      check("rst_read_err",    64'(read_err_w[0]),    64'd0);
      check("rst_btype",       64'(btype_w[0]),       64'd0);
      check("rst_com_field",   com_field_w[0],        64'd0);
      check("rst_ram_rxa",     64'(rxa_w[0]),         64'h80);
      rst = 1'b1;
      repeat (3) tick();

      // ---- nominal transfer, NF=4 LAT=2 ----
      load_nominal();
      sb_q.push_back('{field: 64'h563412A4, btype: 4'h4});
      fs_eth_read_v[0] = 1'b1;
      wait_fs(0, lat);
      check("nom_latency", 64'(lat), 64'd10);
      sb_compare(0, "nom");
      repeat (2) tick();
      check("nom_stable_field", com_field_w[0], 64'h563412A4);
      check("nom_stable_fs", 64'(fs_read_w[0]), 64'd1);
      fd_read_v[0] = 1'b1;
      tick();
      fd_read_v[0] = 1'b0;
      check("nom_ack", 64'(fd_eth_read_w[0]), 64'd1);
      check("nom_fs_drop", 64'(fs_read_w[0]), 64'd0);
      check("nom_no_err", 64'(read_err_w[0]), 64'd0);
      fs_eth_read_v[0] = 1'b0;
      tick();
      check("nom_ack_fall", 64'(fd_eth_read_w[0]), 64'd0);
      tick();
      check("nom_clear_field", com_field_w[0], 64'd0);
      check("nom_clear_btype", 64'(btype_w[0]), 64'd0);
      repeat (2) tick();

      // ---- header mismatch ----
      mem[8'h80] = 8'h54;
      fs_eth_read_v[0] = 1'b1;
      seen_fs = 0;
      cnt = 0;
      while (fd_eth_read_w[0] !== 1'b1 && cnt < 40) begin
         tick();
         cnt++;
         if (fs_read_w[0] === 1'b1) seen_fs++;
      end
      check("hdr_ack", 64'(fd_eth_read_w[0]), 64'd1);
      check("hdr_err", 64'(read_err_w[0]), 64'd1);
      check("hdr_no_fs_read", 64'(seen_fs), 64'd0);
      check("hdr_com_field", com_field_w[0], 64'd0);
      fs_eth_read_v[0] = 1'b0;
      repeat (2) tick();
      check("hdr_err_clear", 64'(read_err_w[0]), 64'd0);
      repeat (2) tick();

      // ---- consumer timeout, TMO=16 ----
      load_nominal();
      sb_q.push_back('{field: 64'h563412A4, btype: 4'h4});
      fs_eth_read_v[0] = 1'b1;
      wait_fs(0, lat);
      check("tmo_latency", 64'(lat), 64'd10);
      sb_compare(0, "tmo");
      cnt = (lat >= 0) ? 1 : 0;
      while (fs_read_w[0] === 1'b1 && cnt < 40) begin
         tick();
         if (fs_read_w[0] === 1'b1) cnt++;
      end
      check("tmo_fs_cycles", 64'(cnt), 64'd16);
      check("tmo_err", 64'(read_err_w[0]), 64'd1);
      check("tmo_ack", 64'(fd_eth_read_w[0]), 64'd1);
      fs_eth_read_v[0] = 1'b0;
      repeat (3) tick();

      // ---- latency sweep, NF=8 ADDR_STEP=1 ----
      for (int g = 1; g < 4; g++) begin
         mem[8'h80] = 8'h55;
         e.field = '0;
         for (int k = 0; k < 8; k++) begin
            mem[8'h85 + k] = 8'($urandom);
            e.field[k*8 +: 8] = mem[8'h85 + k];
         end
         e.btype = mem[8'h85][3:0];
         sb_q.push_back(e);
         fs_eth_read_v[g] = 1'b1;
         wait_fs(g, lat);
         check($sformatf("sweep%0d_latency", lat_tab[g]), 64'(lat), 64'(8 + lat_tab[g] + 4));
         sb_compare(g, $sformatf("sweep%0d", lat_tab[g]));
         fd_read_v[g] = 1'b1;
         tick();
         fd_read_v[g] = 1'b0;
         check($sformatf("sweep%0d_ack", lat_tab[g]), 64'(fd_eth_read_w[g]), 64'd1);
         fs_eth_read_v[g] = 1'b0;
         repeat (3) tick();
      end

      // ---- abort during READ at num=3 ----
      load_nominal();
      fs_eth_read_v[0] = 1'b1;
      repeat (4) tick();
      fs_eth_read_v[0] = 1'b0;
      seen_fs  = 0;
      seen_ack = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (fs_read_w[0] === 1'b1) seen_fs++;
         if (fd_eth_read_w[0] === 1'b1) seen_ack++;
      end
      check("abort_no_fs_read", 64'(seen_fs), 64'd0);
      check("abort_no_ack", 64'(seen_ack), 64'd0);
      sb_q.push_back('{field: 64'h563412A4, btype: 4'h4});
      fs_eth_read_v[0] = 1'b1;
      wait_fs(0, lat);
      check("post_abort_latency", 64'(lat), 64'd10);
      sb_compare(0, "post_abort");
      fd_read_v[0] = 1'b1;
      tick();
      fd_read_v[0] = 1'b0;
      check("post_abort_ack", 64'(fd_eth_read_w[0]), 64'd1);
      fs_eth_read_v[0] = 1'b0;
      repeat (3) tick();

      // ---- asynchronous reset while in WORK ----
      sb_q.push_back('{field: 64'h563412A4, btype: 4'h4});
      fs_eth_read_v[0] = 1'b1;
      wait_fs(0, lat);
      check("arst_latency", 64'(lat), 64'd10);
      sb_compare(0, "arst");
      #2;
      rst = 1'b0;
      #1;
      check("arst_fs_read",     64'(fs_read_w[0]),     64'd0);
      check("arst_fd_eth_read", 64'(fd_eth_read_w[0]), 64'd0);
      check("arst_read_err",    64'(read_err_w[0]),    64'd0);
      check("arst_btype",       64'(btype_w[0]),       64'd0);
      check("arst_com_field",   com_field_w[0],        64'd0);
      check("arst_ram_rxa",     64'(rxa_w[0]),         64'h80);
      fs_eth_read_v[0] = 1'b0;
      #10;
      rst = 1'b1;
      repeat (3) tick();

      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/com_read_multi.md
# com_read_multi

Parametrised command-field reader for the collect-side command path. On a start strobe from the Ethernet receive side it checks a header byte in the receive RAM and reads up to 8 command fields from configurable addresses, tolerating a RAM read latency of 1–4 cycles. It presents the assembled field vector and block type to the command consumer, then handshakes completion back to the Ethernet side. Unlike the fixed four-field reader, it adds header validation, a consumer timeout and an error flag.

## Interface
- DW, 8 — RAM data / field width
- AW, 8 — RAM address width
- NF, 4 — number of command fields, 1..8
- LAT, 2 — RAM read latency in cycles, 1..4
- HEAD_ADDR, 8'h80 — header byte address
- HEAD_VAL, 8'h55 — required header value
- ADDR_FIRST, 8'h85 — address of field 0
- ADDR_STEP, 8'h02 — address stride between fields
- ADDR_IDLE, 8'h80 — address driven when not reading
- TMO, 16'd1000 — cycles allowed for fd_read in WORK
- clk  in  1  — single clock, rising edge
- rst  in  1  — asynchronous, active-low reset
- fs_eth_read  in  1  — start request from the Ethernet side, level-held
- fd_eth_read  out  1  — done/ack to the Ethernet side
- fs_read  out  1  — command valid to the consumer
- fd_read  in  1  — consumer has taken the command
- read_btype  out  4  — field 0 bits [3:0]
- com_field  out  NF*DW  — field k at bits [k*DW +: DW]
- read_err  out  1  — header mismatch or timeout
- ram_rxa  out  AW  — RAM read address, registered
- ram_rxd  in  DW  — RAM read data

## Operation
- Reset values:
  - fd_eth_read = 0, fs_read = 0, read_err = 0
  - read_btype = 0, com_field = 0, ram_rxa = ADDR_IDLE
  - state = IDLE, num = 0, tmo_cnt = 0
- IDLE (1 cycle): clears com_field, read_btype, read_err, num, tmo_cnt. Goes to WAIT.
- WAIT: on fs_eth_read = 1 go to READ, otherwise stay.
- READ: num increments every cycle from 0.
  - Address issue: at num = 0, ram_rxa <= HEAD_ADDR.
  - At num = k for k = 1..NF, ram_rxa <= ADDR_FIRST + (k-1)*ADDR_STEP, truncated to AW bits (wraps).
  - Otherwise ram_rxa <= ADDR_IDLE.
  - Capture: at the end of the cycle with num = j + LAT, slot j is registered from ram_rxd. Slot 0 is the header; slots 1..NF are fields 0..NF-1.
  - When num = NF + LAT, go to CHECK.
- CHECK: if header ≠ HEAD_VAL go to FAIL, otherwise go to TAKE.
- TAKE: com_field <= the captured fields; read_btype <= field0[3:0]. Go to WORK.
- WORK: fs_read = 1 and tmo_cnt increments.
  - fd_read = 1: go to DONE.
  - Else tmo_cnt = TMO-1: go to FAIL.
- DONE: fd_eth_read = 1. On fs_eth_read = 0 go to IDLE.
- FAIL: read_err = 1 and fd_eth_read = 1. On fs_eth_read = 0 go to IDLE.
- Abort: fs_eth_read = 0 while in READ, CHECK, TAKE or WORK goes to IDLE next cycle. No fd_eth_read pulse is produced.
- Simultaneous fd_read and timeout terminal count in WORK: fd_read wins (DONE).
- Unused state encodings go to IDLE.
- fs_read, fd_eth_read and read_err are decoded from state, one-hot.

## Timing
- RAM model:
  - LAT = 1: ram_rxd is combinational from ram_rxa.
  - LAT = n: ram_rxd is ram_rxa delayed by n-1 registered stages.
- Latency from the first WAIT cycle with fs_eth_read = 1 to fs_read = 1 is NF + LAT + 4 cycles: READ lasts NF+LAT+1 cycles, then CHECK, TAKE, WORK. For NF = 4, LAT = 2 this is 10 cycles.
- com_field and read_btype are stable from the first fs_read cycle until the next IDLE.
- fd_eth_read rises 1 cycle after fd_read is sampled in WORK. It falls 1 cycle after fs_eth_read = 0 is sampled.
- The timeout fires after exactly TMO WORK cycles without fd_read.
- Reset asserted mid-transaction immediately forces all reset values.

## Test plan
- Nominal transfer, NF = 4, LAT = 2.
  - Stimulus: RAM 80 = 55, 85 = A4, 87 = 12, 89 = 34, 8B = 56; fs_eth_read = 1.
  - Required: fs_read rises at cycle 10; com_field = 32'h563412A4; read_btype = 4'h4.
  - Then fd_read = 1 → fd_eth_read = 1 next cycle; drop fs_eth_read → IDLE and outputs cleared.
- Header mismatch: RAM 80 = 54 → read_err = 1 and fd_eth_read = 1, fs_read never asserted, com_field = 0.
- Timeout, TMO = 16: fd_read held 0 → fs_read high for exactly 16 cycles, then read_err = 1.
- Latency sweep: LAT = 1, 3, 4 with NF = 8, ADDR_STEP = 1 → all 8 fields correct; fs_read at cycle NF + LAT + 4.
- Abort: drop fs_eth_read at READ num = 3 → IDLE next cycle, no fd_eth_read pulse; a following request completes normally.
- Asynchronous reset asserted in WORK → all outputs at reset values before the next clock edge; ram_rxa = 8'h80.
